// File: rtl/acc_array_q.sv
// Multi-column output accumulator: sums partial sums over several passes per pixel,
// then bias, rounding shift, optional ReLU and saturation on the final pass.
module acc_array_q #(
    parameter int N_COL  = 16,
    parameter int PSUM_W = 32,
    parameter int OUT_W  = 8,
    parameter int PIX_AW = 10,
    parameter int SIZE_W = 5,
    parameter int PASS_W = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [SIZE_W-1:0]         ofmap_size_i,
    input  logic [PASS_W-1:0]         n_pass_i,
    input  logic [4:0]                shift_i,
    input  logic                      relu_en_i,
    input  logic [N_COL*PSUM_W-1:0]   bias_i,
    input  logic [N_COL*PSUM_W-1:0]   psum_i,
    input  logic [N_COL-1:0]          pvalid_i,
    output logic [N_COL-1:0]          pready_o,
    output logic [N_COL-1:0]          conv_valid_o,
    input  logic [N_COL-1:0]          conv_ready_i,
    output logic [N_COL*OUT_W-1:0]    conv_result_o,
    output logic [N_COL-1:0]          conv_last_o,
    output logic [N_COL*PIX_AW-1:0]   addr_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int DEPTH = 1 << PIX_AW;
    localparam int SQ_W  = 2 * SIZE_W;
    localparam logic signed [PSUM_W:0] SAT_MAX = (PSUM_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [PSUM_W:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Job configuration, captured on start_i
    logic [PIX_AW-1:0]          pix_last_q, pix_last_d;
    logic [PASS_W-1:0]          pass_last_q, pass_last_d;
    logic [4:0]                 shift_q, shift_d;
    logic                       relu_q, relu_d;
    logic signed [PSUM_W-1:0]   bias_q [N_COL];
    logic signed [PSUM_W-1:0]   bias_d [N_COL];
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    // Per-column control and output registers
    state_t                     state_q [N_COL];
    state_t                     state_d [N_COL];
    logic [PIX_AW-1:0]          pix_q   [N_COL];
    logic [PIX_AW-1:0]          pix_d   [N_COL];
    logic [PASS_W-1:0]          pass_q  [N_COL];
    logic [PASS_W-1:0]          pass_d  [N_COL];
    logic                       vld_q   [N_COL];
    logic                       vld_d   [N_COL];
    logic signed [OUT_W-1:0]    res_q   [N_COL];
    logic signed [OUT_W-1:0]    res_d   [N_COL];
    logic                       last_q  [N_COL];
    logic                       last_d  [N_COL];
    logic [PIX_AW-1:0]          addr_q  [N_COL];
    logic [PIX_AW-1:0]          addr_d  [N_COL];

    // Pixel buffers are never reset; pass 0 overwrites every entry
    logic signed [PSUM_W-1:0]   buf_q   [N_COL][DEPTH];
    logic [N_COL-1:0]           wr_en;
    logic signed [PSUM_W-1:0]   wr_data [N_COL];

    logic [N_COL-1:0]           pready;
    logic [N_COL-1:0]           accept;
    logic                       all_done;
    logic                       empty_job;
    logic [SQ_W-1:0]            sq;

    function automatic logic signed [PSUM_W:0] round_shift(
        input logic signed [PSUM_W-1:0] s,
        input logic [4:0]               sh
    );
        logic signed [PSUM_W:0] ext;
        logic signed [PSUM_W:0] half;
        ext  = {s[PSUM_W-1], s};
        half = '0;
        if (sh != 5'd0) begin
            half = {{PSUM_W{1'b0}}, 1'b1} << (sh - 5'd1);
        end
        return (ext + half) >>> sh;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(
        input logic signed [PSUM_W:0] v,
        input logic                   relu
    );
        logic signed [PSUM_W:0] t;
        t = v;
        if (relu && (t < 0)) t = '0;
        if (t > SAT_MAX) t = SAT_MAX;
        if (t < SAT_MIN) t = SAT_MIN;
        return t[OUT_W-1:0];
    endfunction

    always_comb begin
        sq          = ofmap_size_i * ofmap_size_i;
        empty_job   = (ofmap_size_i == '0);
        all_done    = busy_q;
        for (int c = 0; c < N_COL; c++) begin
            if (state_q[c] != S_DONE) all_done = 1'b0;
        end

        pix_last_d  = pix_last_q;
        pass_last_d = pass_last_q;
        shift_d     = shift_q;
        relu_d      = relu_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        for (int c = 0; c < N_COL; c++) bias_d[c] = bias_q[c];

        if (start_i) begin
            pix_last_d  = PIX_AW'(sq - SQ_W'(1));
            pass_last_d = (n_pass_i == '0) ? '0 : n_pass_i - PASS_W'(1);
            shift_d     = shift_i;
            relu_d      = relu_en_i;
            busy_d      = !empty_job;
            done_d      = empty_job;
            for (int c = 0; c < N_COL; c++) bias_d[c] = bias_i[c*PSUM_W +: PSUM_W];
        end else if (all_done) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
    end

    always_comb begin
        logic signed [PSUM_W-1:0] psum_c;
        logic signed [PSUM_W-1:0] base_c;
        logic signed [PSUM_W-1:0] sum_c;
        logic                     final_c;
        logic                     last_pix_c;
        for (int c = 0; c < N_COL; c++) begin
            state_d[c] = state_q[c];
            pix_d[c]   = pix_q[c];
            pass_d[c]  = pass_q[c];
            vld_d[c]   = vld_q[c];
            res_d[c]   = res_q[c];
            last_d[c]  = last_q[c];
            addr_d[c]  = addr_q[c];

            psum_c     = psum_i[c*PSUM_W +: PSUM_W];
            final_c    = (pass_q[c] == pass_last_q);
            last_pix_c = (pix_q[c] == pix_last_q);
            // Pass 0 starts fresh; later passes add to the stored partial sum
            base_c     = (pass_q[c] == '0) ? psum_c : buf_q[c][pix_q[c]] + psum_c;
            sum_c      = base_c + bias_q[c];

            pready[c]  = (state_q[c] == S_ACC) &&
                         (!final_c || !vld_q[c] || conv_ready_i[c]);
            accept[c]  = pvalid_i[c] && pready[c];
            wr_en[c]   = accept[c] && !final_c && !start_i;
            wr_data[c] = base_c;

            if (start_i) begin
                state_d[c] = empty_job ? S_IDLE : S_ACC;
                pix_d[c]   = '0;
                pass_d[c]  = '0;
                vld_d[c]   = 1'b0;
                last_d[c]  = 1'b0;
            end else begin
                case (state_q[c])
                    S_ACC: begin
                        if (vld_q[c] && conv_ready_i[c]) vld_d[c] = 1'b0;
                        if (accept[c]) begin
                            if (final_c) begin
                                vld_d[c]  = 1'b1;
                                res_d[c]  = saturate(round_shift(sum_c, shift_q), relu_q);
                                addr_d[c] = pix_q[c];
                                last_d[c] = last_pix_c;
                            end
                            if (last_pix_c) begin
                                pix_d[c] = '0;
                                if (final_c) state_d[c] = S_DRAIN;
                                else         pass_d[c]  = pass_q[c] + 1'b1;
                            end else begin
                                pix_d[c] = pix_q[c] + 1'b1;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (vld_q[c] && conv_ready_i[c]) begin
                            vld_d[c]   = 1'b0;
                            state_d[c] = S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (all_done) state_d[c] = S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_last_q  <= '0;
            pass_last_q <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int c = 0; c < N_COL; c++) begin
                state_q[c] <= S_IDLE;
                pix_q[c]   <= '0;
                pass_q[c]  <= '0;
                vld_q[c]   <= 1'b0;
                res_q[c]   <= '0;
                last_q[c]  <= 1'b0;
                addr_q[c]  <= '0;
            end
        end else begin
            pix_last_q  <= pix_last_d;
            pass_last_q <= pass_last_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            for (int c = 0; c < N_COL; c++) begin
                state_q[c] <= state_d[c];
                pix_q[c]   <= pix_d[c];
                pass_q[c]  <= pass_d[c];
                vld_q[c]   <= vld_d[c];
                res_q[c]   <= res_d[c];
                last_q[c]  <= last_d[c];
                addr_q[c]  <= addr_d[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < N_COL; c++) begin
            bias_q[c] <= bias_d[c];
            if (wr_en[c]) buf_q[c][pix_q[c]] <= wr_data[c];
        end
    end

    always_comb begin
        conv_result_o = '0;
        addr_o        = '0;
        conv_valid_o  = '0;
        conv_last_o   = '0;
        for (int c = 0; c < N_COL; c++) begin
            conv_result_o[c*OUT_W +: OUT_W]  = res_q[c];
            addr_o[c*PIX_AW +: PIX_AW]       = addr_q[c];
            conv_valid_o[c]                  = vld_q[c];
            conv_last_o[c]                   = last_q[c];
        end
    end

    assign pready_o = pready;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_acc_array_q.sv
// Scoreboard bench for acc_array_q: a reference model fills per-column expectation
// queues at job issue; a monitor pops and compares on every output handshake.
module tb_acc_array_q;

    localparam int N  = 16;
    localparam int PW = 32;
    localparam int OW = 8;
    localparam int AW = 10;
    localparam int SW = 5;
    localparam int NW = 6;

    logic              clk;
    logic              rst;
    logic              start_i;
    logic [SW-1:0]     ofmap_size_i;
    logic [NW-1:0]     n_pass_i;
    logic [4:0]        shift_i;
    logic              relu_en_i;
    logic [N*PW-1:0]   bias_i;
    logic [N*PW-1:0]   psum_i;
    logic [N-1:0]      pvalid_i;
    logic [N-1:0]      pready_o;
    logic [N-1:0]      conv_valid_o;
    logic [N-1:0]      conv_ready_i;
    logic [N*OW-1:0]   conv_result_o;
    logic [N-1:0]      conv_last_o;
    logic [N*AW-1:0]   addr_o;
    logic              busy_o;
    logic              done_o;

    acc_array_q dut (
        .clk(clk), .rst(rst), .start_i(start_i), .ofmap_size_i(ofmap_size_i),
        .n_pass_i(n_pass_i), .shift_i(shift_i), .relu_en_i(relu_en_i),
        .bias_i(bias_i), .psum_i(psum_i), .pvalid_i(pvalid_i), .pready_o(pready_o),
        .conv_valid_o(conv_valid_o), .conv_ready_i(conv_ready_i),
        .conv_result_o(conv_result_o), .conv_last_o(conv_last_o), .addr_o(addr_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] res;
        logic [AW-1:0] addr;
        logic          last;
    } exp_t;

    exp_t               exp_q [N][$];
    int                 errors = 0;
    int                 checks = 0;
    logic signed [31:0] stim   [N][64];
    logic signed [31:0] bias_v [N];
    int                 skew   [N];
    int                 stall_from = 0;
    int                 stall_len  = 0;
    int                 pv_prob    = 100;
    bit                 rand_ready = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: total of all passes plus bias (32-bit wrap), round-half-up shift,
    // ReLU, clamp to the signed 8-bit range.
    function automatic logic [OW-1:0] model_pixel(int c, int p, int P, int np, int sh, bit rl);
        logic signed [31:0] acc;
        longint s, r;
        acc = bias_v[c];
        for (int k = 0; k < np; k++) acc = acc + stim[c][k*P+p];
        s = acc;
        if (sh > 0) r = (s + (longint'(1) << (sh - 1))) >>> sh;
        else        r = s;
        if (rl && r < 0) r = 0;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return r[OW-1:0];
    endfunction

    task automatic push_expected(int sz, int np, int sh, bit rl);
        int P;
        exp_t e;
        P = sz * sz;
        for (int c = 0; c < N; c++) begin
            for (int p = 0; p < P; p++) begin
                e.res  = model_pixel(c, p, P, np, sh, rl);
                e.addr = p[AW-1:0];
                e.last = (p == P - 1);
                exp_q[c].push_back(e);
            end
        end
    endtask

    // Monitor: compare on each handshake, and check that a stalled output holds still
    initial begin
        bit            held [N];
        logic [OW-1:0] h_res [N];
        logic [AW-1:0] h_addr [N];
        logic          h_last [N];
        exp_t          e;
        for (int c = 0; c < N; c++) held[c] = 0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                if (rst || !conv_valid_o[c]) begin
                    held[c] = 0;
                end else begin
                    if (held[c]) begin
                        check($sformatf("hold res c%0d", c), conv_result_o[c*OW +: OW], h_res[c]);
                        check($sformatf("hold addr c%0d", c), addr_o[c*AW +: AW], h_addr[c]);
                        check($sformatf("hold last c%0d", c), conv_last_o[c], h_last[c]);
                    end
                    if (conv_ready_i[c]) begin
                        held[c] = 0;
                        if (exp_q[c].size() == 0) begin
                            check($sformatf("unexpected output c%0d", c), 1, 0);
                        end else begin
                            e = exp_q[c].pop_front();
                            check($sformatf("res c%0d", c), $signed(conv_result_o[c*OW +: OW]), $signed(e.res));
                            check($sformatf("addr c%0d", c), addr_o[c*AW +: AW], e.addr);
                            check($sformatf("last c%0d", c), conv_last_o[c], e.last);
                        end
                    end else begin
                        held[c]   = 1;
                        h_res[c]  = conv_result_o[c*OW +: OW];
                        h_addr[c] = addr_o[c*AW +: AW];
                        h_last[c] = conv_last_o[c];
                        check($sformatf("pready in stall c%0d", c), pready_o[c], 0);
                    end
                end
            end
        end
    end

    task automatic run_job(input int sz, input int np, input int sh, input bit rl, input int abort_cyc);
        int P, np1, total, cyc;
        int idx [N];
        bit accd [N];
        P     = sz * sz;
        np1   = (np == 0) ? 1 : np;
        total = P * np1;
        if (abort_cyc == 0) push_expected(sz, np1, sh, rl);
        @(posedge clk); #1;
        ofmap_size_i = SW'(sz);
        n_pass_i     = NW'(np);
        shift_i      = 5'(sh);
        relu_en_i    = rl;
        for (int c = 0; c < N; c++) begin
            bias_i[c*PW +: PW] = bias_v[c];
            idx[c]  = 0;
            accd[c] = 0;
        end
        pvalid_i     = '0;
        conv_ready_i = '1;
        start_i      = 1'b1;
        @(posedge clk); #1;
        start_i      = 1'b0;
        ofmap_size_i = SW'($urandom);
        n_pass_i     = NW'($urandom);
        shift_i      = 5'($urandom);
        relu_en_i    = ~rl;
        for (int c = 0; c < N; c++) bias_i[c*PW +: PW] = $urandom;
        cyc = 0;
        while (1) begin
            for (int c = 0; c < N; c++) begin
                if (accd[c]) idx[c]++;
                if (cyc >= skew[c] && idx[c] < total && $urandom_range(99) < pv_prob) begin
                    pvalid_i[c]        = 1'b1;
                    psum_i[c*PW +: PW] = stim[c][idx[c]];
                end else begin
                    pvalid_i[c]        = 1'b0;
                    psum_i[c*PW +: PW] = $urandom;
                end
                if (cyc >= stall_from && cyc < stall_from + stall_len) conv_ready_i[c] = 1'b0;
                else if (rand_ready) conv_ready_i[c] = ($urandom_range(3) != 0);
                else conv_ready_i[c] = 1'b1;
            end
            @(negedge clk);
            if (cyc == 0) check("busy after start", busy_o, (sz != 0));
            for (int c = 0; c < N; c++) begin
                accd[c] = pvalid_i[c] && pready_o[c];
                if (idx[c] < (np1 - 1) * P)
                    check($sformatf("pready nonfinal c%0d", c), pready_o[c], 1);
            end
            if (abort_cyc > 0 && cyc + 1 >= abort_cyc) return;
            if (done_o) break;
            cyc++;
            if (cyc > 4000) begin
                check("done timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
        end
        if (sz == 0) check("size0 done latency", cyc, 0);
        for (int c = 0; c < N; c++) begin
            check($sformatf("psums consumed c%0d", c), idx[c], total);
            check($sformatf("results left c%0d", c), exp_q[c].size(), 0);
        end
        check("busy at done", busy_o, 0);
        @(posedge clk); #1;
        pvalid_i = '0;
        @(negedge clk);
        check("done pulse width", done_o, 0);
    endtask

    task automatic rand_stim();
        for (int c = 0; c < N; c++) begin
            bias_v[c] = ($urandom_range(4) == 0) ? $urandom : $urandom_range(10000) - 5000;
            for (int k = 0; k < 64; k++)
                stim[c][k] = ($urandom_range(3) == 0) ? $urandom : $urandom_range(2000) - 1000;
        end
    endtask

    task automatic set_col0(input int k, input int v);
        for (int c = 0; c < N; c++) stim[c][k] = v;
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; ofmap_size_i = '0; n_pass_i = '0; shift_i = '0;
        relu_en_i = 1'b0; bias_i = '0; psum_i = '0; pvalid_i = '0; conv_ready_i = '0;
        for (int c = 0; c < N; c++) begin skew[c] = 0; bias_v[c] = 0; end
        repeat (2) @(posedge clk);
        #1;
        check("rst pready", pready_o, 0);
        check("rst valid", conv_valid_o, 0);
        check("rst result", |conv_result_o, 0);
        check("rst last", conv_last_o, 0);
        check("rst addr", |addr_o, 0);
        check("rst busy", busy_o, 0);
        check("rst done", done_o, 0);
        rst = 1'b0;

        // Single pass with saturation at both ends
        set_col0(0, 5); set_col0(1, -3); set_col0(2, 200); set_col0(3, -200);
        run_job(2, 1, 0, 0, 0);

        // Three passes of 10 with bias 4, shift 2
        for (int k = 0; k < 27; k++) set_col0(k, 10);
        for (int c = 0; c < N; c++) bias_v[c] = 4;
        run_job(3, 3, 2, 0, 0);

        // ReLU and rounding
        set_col0(0, -7); set_col0(1, 3); set_col0(2, 5); set_col0(3, 0);
        for (int c = 0; c < N; c++) bias_v[c] = 0;
        run_job(2, 1, 1, 1, 0);

        // Backpressure in the middle of the final pass
        rand_stim();
        stall_from = 12; stall_len = 5;
        run_job(3, 2, 1, 0, 0);
        stall_len = 0;

        // Column 15 lags column 0 by four cycles
        rand_stim();
        skew[15] = 4;
        run_job(2, 2, 0, 0, 0);
        skew[15] = 0;

        // Restart during pass 1, then a fresh job over stale buffer contents
        rand_stim();
        run_job(3, 3, 0, 0, 12);
        rand_stim();
        run_job(3, 2, 3, 1, 0);

        // Empty ofmap
        run_job(0, 2, 0, 0, 0);

        // Asynchronous reset with outputs pending
        for (int k = 0; k < 4; k++) set_col0(k, 50);
        for (int c = 0; c < N; c++) bias_v[c] = 0;
        stall_from = 0; stall_len = 1000;
        run_job(2, 1, 0, 0, 4);
        check("pre-reset valid", conv_valid_o, {N{1'b1}});
        #2;
        rst = 1'b1;
        #1;
        check("mid rst valid", conv_valid_o, 0);
        check("mid rst result", |conv_result_o, 0);
        check("mid rst addr", |addr_o, 0);
        check("mid rst last", conv_last_o, 0);
        check("mid rst busy", busy_o, 0);
        check("mid rst done", done_o, 0);
        check("mid rst pready", pready_o, 0);
        stall_len = 0;
        pvalid_i = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < N; c++) exp_q[c].delete();

        // Randomized jobs with random gaps, skew and downstream ready
        pv_prob = 70; rand_ready = 1;
        for (int j = 0; j < 10; j++) begin
            rand_stim();
            for (int c = 0; c < N; c++) skew[c] = $urandom_range(3);
            run_job($urandom_range(1, 5), $urandom_range(0, 2),
                    ($urandom_range(3) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 8),
                    $urandom_range(1), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acc_array_q.md
# acc_array_q

Parametrised N_COL-column output accumulator placed between the systolic array and the activation/writeback stage. Each column sums partial sums over multiple input-channel passes into a per-column pixel buffer. On the final pass it adds a per-column bias, applies a rounding arithmetic shift, optional ReLU and saturation, and emits OUT_W-bit results over a valid/ready handshake with backpressure.

## Interface
- N_COL, 16, number of columns
- PSUM_W, 32, signed psum/accumulator width
- OUT_W, 8, signed result width
- PIX_AW, 10, pixel-buffer address width; depth 2^PIX_AW per column
- SIZE_W, 5, ofmap_size width
- PASS_W, 6, pass-count width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse; latches config, clears counters, enters busy
- ofmap_size_i  in  SIZE_W  output side length; pixels per pass P = size^2
- n_pass_i  in  PASS_W  accumulation passes (input-channel tiles); 0 treated as 1
- shift_i  in  5  requant right-shift amount
- relu_en_i  in  1  clamp negatives to 0
- bias_i  in  [N_COL] x PSUM_W  signed per-column bias, latched on start_i
- psum_i  in  [N_COL] x PSUM_W  signed partial sums
- pvalid_i  in  [N_COL] x 1  psum valid
- pready_o  out  [N_COL] x 1  psum accepted when pvalid_i && pready_o
- conv_valid_o  out  [N_COL] x 1  result valid
- conv_ready_i  in  [N_COL] x 1  downstream ready
- conv_result_o  out  [N_COL] x OUT_W  signed result
- conv_last_o  out  [N_COL] x 1  marks pixel P-1 of final pass
- addr_o  out  [N_COL] x PIX_AW  pixel index of conv_result_o
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse when all columns have finished

## Operation
- Config (size, n_pass, shift, relu_en, bias) is latched on start_i and held for the job; input changes mid-job are ignored.
- Per-column FSM: IDLE -> ACC (on start_i) -> DRAIN (last psum of final pass accepted) -> DONE (last result handshaken) -> IDLE (with done_o).
- Per-column counters pix (0..P-1) and pass (0..n_pass-1) advance on each accepted psum. pix wraps to 0 and pass increments at P-1.
- Psums arrive in raster pixel order, one full pass at a time.
- Pass 0: buf[pix] <= psum. Middle passes: buf[pix] <= buf[pix] + psum. Combinational read, same-cycle write.
- Final pass: s = buf[pix] + psum + bias, or psum + bias if n_pass = 1. The result is not written back.
- Requant: if shift > 0, r = (s + 2^(shift-1)) >>> shift, else r = s.
- ReLU: if relu_en and r < 0 then r = 0.
- Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- All adds wrap at PSUM_W bits (two's complement). Rounding/shift is computed at PSUM_W+1 bits to avoid overflow.
- Columns run independently. done_o fires the cycle after the last column reaches DONE; busy_o then clears.
- ofmap_size = 0: no transfers; done_o pulses the cycle after start_i.
- start_i while busy: restart the job. All columns return to ACC with counters 0; any pending output is dropped (conv_valid_o -> 0).
- Pixel buffer is not reset; pass 0 overwrites it.

## Timing
- Reset values: pready_o 0, conv_valid_o 0, conv_result_o 0, conv_last_o 0, addr_o 0, busy_o 0, done_o 0. All FSMs IDLE, counters 0.
- pready_o is 0 in IDLE, DRAIN, DONE. In non-final passes of ACC it is 1. In the final pass it is !conv_valid_o || conv_ready_i for that column.
- Result latency: 1 cycle. The accepted final-pass psum at cycle t gives conv_valid_o at t+1.
- Sustained rate: 1 result/cycle per column while conv_ready_i = 1.
- While conv_valid_o && !conv_ready_i, result, addr and last hold stable and no psum is accepted.
- The cycle after start_i, busy_o = 1 and pready_o follows the rules above.
- In IDLE, pvalid_i is ignored.

## Test plan
- Single pass: size=2, n_pass=1, bias=0, shift=0. Psums 5,-3,200,-200 -> results 5,-3,127,-128; addr 0..3; last on addr 3; done_o 1 cycle later.
- Three passes: size=3, n_pass=3, psum=10 every pixel, bias=4, shift=2 -> all 9 results (34+2)>>>2 = 9. pready_o stays 1 through passes 0-1.
- ReLU + rounding: n_pass=1, shift=1, relu_en=1. Psums -7, 3, 5 -> results 0, 2, 3.
- Backpressure: hold conv_ready_i=0 for 5 cycles mid final pass. Output is stable, pready_o=0, no psum is lost; the result sequence matches the no-stall run.
- Columns skewed: column 0 fed 4 cycles ahead of column 15. done_o pulses only after column 15's last handshake; both columns' results are correct.
- Restart and reset: start_i mid pass 1, then a fresh job gives results unaffected by the old data. Asserting rst mid-job immediately zeroes all outputs and busy_o.
